// File: rtl/key_event_fifo_if.sv
// Bundles the decoder-side key strobe and the consumer-side event handshake.
// Pure wiring, no latency.
// Backpressure is carried by evt_ready on the consumer side; the decoder side has none.
interface key_event_fifo_if #(
  parameter int DEPTH = 4
);
  logic                       key_valid;
  logic [8:0]                 last_change;
  logic [511:0]               key_down;
  logic                       evt_valid;
  logic                       evt_id;
  logic                       evt_ready;
  logic [$clog2(DEPTH):0]     count;
  logic                       overflow;
  logic [7:0]                 drop_cnt;

  // Decoder and consumer side: drives key inputs and ready, observes events.
  modport master (
    output key_valid, last_change, key_down, evt_ready,
    input  evt_valid, evt_id, count, overflow, drop_cnt
  );

  // Event queue side.
  modport slave (
    input  key_valid, last_change, key_down, evt_ready,
    output evt_valid, evt_id, count, overflow, drop_cnt
  );
endinterface

// File: rtl/key_event_fifo.sv
// Extracts make events for two station keys (typematic repeats filtered) and queues them.
// Latency: one clock from key_valid strobe to visible evt_valid/count.
// Backpressure: events wait in a DEPTH-entry FIFO; a make arriving when full is dropped and counted.
module key_event_fifo #(
  parameter int         DEPTH = 4,
  parameter logic [8:0] KEY_A = 9'h069,
  parameter logic [8:0] KEY_B = 9'h072
) (
  input logic             clk,
  input logic             rst,
  key_event_fifo_if.slave bus
);
  localparam int              AW   = $clog2(DEPTH);
  localparam int              CW   = AW + 1;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          mem [DEPTH];
  logic [1:0]    held;
  logic          overflow_q;
  logic [7:0]    drop_q;

  logic is_a, is_b, hit, id, down;
  logic make, brk, fresh, pop, push, drop;

  // Classify the decoder strobe and resolve push/pop/drop for this cycle.
  always_comb begin
    is_a  = (bus.last_change == KEY_A);
    is_b  = (bus.last_change == KEY_B);
    hit   = is_a | is_b;
    id    = is_b;
    down  = bus.key_down[bus.last_change];
    make  = bus.key_valid & hit & down;
    brk   = bus.key_valid & hit & ~down;
    // Only the first make after a break counts; repeats while held are ignored.
    fresh = make & ~held[id];
    pop   = (count_q != '0) & bus.evt_ready;
    // A full FIFO still takes the event if the head leaves in the same cycle.
    push  = fresh & ((count_q < FULL) | pop);
    drop  = fresh & ~push;
  end

  // Per-key held flags: set by any make (even a dropped one), cleared by a break.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held <= 2'b00;
    end else if (make) begin
      held[id] <= 1'b1;
    end else if (brk) begin
      held[id] <= 1'b0;
    end
  end

  // Storage array; contents are meaningless outside [rd_ptr, rd_ptr+count).
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= id;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_q     <= 8'd0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  assign bus.evt_valid = (count_q != '0);
  assign bus.evt_id    = (count_q != '0) ? mem[rd_ptr] : 1'b0;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_q;
endmodule
